// File: rtl/irq_controller.sv
// Edge-latching interrupt controller: masks pending requests, presents the lowest-index eligible
// source to the core, and keeps it in service until software writes COMPLETE through the bus window.
module irq_controller #(
   parameter int          N_SRC       = 4,
   parameter logic [63:0] BASE_ADDR   = 64'h0000_2000,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_src,
   output logic [3:0]       interrupt_vector,
   input  logic             interrupt_ack,
   input  logic [63:0]      bus_address,
   input  logic [63:0]      bus_write_data,
   input  logic             bus_write_enable,
   input  logic             bus_read_enable,
   output logic [63:0]      bus_read_data
);

   localparam int            TW         = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ASSERT, ST_GAP, ST_ACTIVE} state_t;

   state_t             state_reg, state_next;
   logic [3:0]         id_reg, id_next;
   logic [3:0]         vector_reg, vector_next;
   logic [TW-1:0]      timer_reg, timer_next;
   logic [N_SRC-1:0]   enable_reg, enable_next;
   logic [N_SRC-1:0]   pending_reg, pending_next;
   logic [N_SRC-1:0]   src_q_reg;
   logic [63:0]        read_data_reg, read_data_next;

   logic [N_SRC-1:0]   edge_set;
   logic [N_SRC-1:0]   eligible;
   logic [N_SRC-1:0]   id_mask;
   logic [N_SRC-1:0]   ack_clear;
   logic [3:0]         winner;
   logic               hit_enable, hit_pending, hit_claim;
   logic               wr_enable, wr_claim;

   assign hit_enable  = (bus_address == BASE_ADDR);
   assign hit_pending = (bus_address == BASE_ADDR + 64'h8);
   assign hit_claim   = (bus_address == BASE_ADDR + 64'h10);
   assign wr_enable   = bus_write_enable & hit_enable;
   assign wr_claim    = bus_write_enable & hit_claim;

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_edge
         assign edge_set[gi] = irq_src[gi] & ~src_q_reg[gi];
      end
   endgenerate

   assign eligible = pending_reg & enable_reg;
   assign id_mask  = N_SRC'(1) << id_reg;

   // Descending scan so the lowest set index is the last assignment and wins.
   always_comb begin
      winner = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (eligible[i]) winner = 4'(i);
      end
   end

   always_comb begin
      state_next  = state_reg;
      id_next     = id_reg;
      vector_next = vector_reg;
      timer_next  = timer_reg;
      ack_clear   = '0;
      case (state_reg)
         ST_IDLE: begin
            if (|eligible) begin
               id_next     = winner;
               vector_next = winner + 4'd1;
               timer_next  = '0;
               state_next  = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (interrupt_ack) begin
               ack_clear   = id_mask;
               vector_next = 4'd0;
               state_next  = ST_ACTIVE;
            end else if (wr_enable && ((bus_write_data[N_SRC-1:0] & id_mask) == '0)) begin
               vector_next = 4'd0;
               state_next  = ST_IDLE;
            end else if (timer_reg == TIMER_LAST) begin
               vector_next = 4'd0;
               state_next  = ST_GAP;
            end else if (timer_reg != '1) begin
               timer_next = timer_reg + TW'(1);
            end
         end
         ST_GAP: begin
            vector_next = 4'd0;
            state_next  = ST_IDLE;
         end
         ST_ACTIVE: begin
            vector_next = 4'd0;
            if (wr_claim && (bus_write_data[3:0] == id_reg + 4'd1)) state_next = ST_IDLE;
         end
         default: begin
            vector_next = 4'd0;
            state_next  = ST_IDLE;
         end
      endcase
   end

   // A new edge on a bit being acknowledged keeps it pending.
   assign pending_next = (pending_reg & ~ack_clear) | edge_set;
   assign enable_next  = wr_enable ? bus_write_data[N_SRC-1:0] : enable_reg;

   always_comb begin
      read_data_next = '0;
      if (bus_read_enable) begin
         if (hit_enable)       read_data_next = 64'(enable_reg);
         else if (hit_pending) read_data_next = 64'(pending_reg);
         else if (hit_claim && state_reg == ST_ACTIVE) read_data_next = 64'(id_reg + 4'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         id_reg        <= '0;
         vector_reg    <= '0;
         timer_reg     <= '0;
         enable_reg    <= '0;
         pending_reg   <= '0;
         src_q_reg     <= '0;
         read_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         id_reg        <= id_next;
         vector_reg    <= vector_next;
         timer_reg     <= timer_next;
         enable_reg    <= enable_next;
         pending_reg   <= pending_next;
         src_q_reg     <= irq_src;
         read_data_reg <= read_data_next;
      end
   end

   assign interrupt_vector = vector_reg;
   assign bus_read_data    = read_data_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed vector table, a hand-written timeout sequence,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_irq_controller;

   localparam logic [63:0] BASE    = 64'h0000_2000;
   localparam int          TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  irq_src = '0;
   logic        ack = 1'b0;
   logic [63:0] addr = '0;
   logic [63:0] wdata = '0;
   logic        we = 1'b0;
   logic        re = 1'b0;
   logic [3:0]  vec;
   logic [63:0] rd;

   int total = 0;
   int bad = 0;

   irq_controller #(.N_SRC(4), .BASE_ADDR(BASE), .ACK_TIMEOUT(TIMEOUT)) dut (
      .clk              (clk),
      .reset            (reset),
      .irq_src          (irq_src),
      .interrupt_vector (vec),
      .interrupt_ack    (ack),
      .bus_address      (addr),
      .bus_write_data   (wdata),
      .bus_write_enable (we),
      .bus_read_enable  (re),
      .bus_read_data    (rd)
   );

   always #5 clk = ~clk;

   // Model: which source is offered to the core, which one is in service,
   // how long the offer has stood, and how many edges must pass before the next pick.
   int          m_offer = -1;
   int          m_service = -1;
   int          m_age = 0;
   int          m_skip = 0;
   logic [3:0]  m_pend = '0;
   logic [3:0]  m_en = '0;
   logic [3:0]  m_srcq = '0;
   logic [3:0]  m_vec = '0;
   logic [63:0] m_rd = '0;

   task automatic model_step();
      logic [3:0] edges;
      logic [3:0] clr;
      logic       wr_en, wr_claim;
      if (reset) begin
         m_offer = -1; m_service = -1; m_age = 0; m_skip = 0;
         m_pend = '0; m_en = '0; m_srcq = '0; m_vec = '0; m_rd = '0;
         return;
      end
      edges    = irq_src & ~m_srcq;
      clr      = '0;
      wr_en    = we && (addr == BASE);
      wr_claim = we && (addr == BASE + 64'h10);
      m_rd = '0;
      if (re) begin
         if (addr == BASE) m_rd = 64'(m_en);
         else if (addr == BASE + 64'h8) m_rd = 64'(m_pend);
         else if (addr == BASE + 64'h10 && m_service >= 0) m_rd = 64'(m_service + 1);
      end
      if (m_offer >= 0) begin
         if (ack) begin
            clr[m_offer] = 1'b1;
            m_service = m_offer;
            m_offer = -1;
         end else if (wr_en && !wdata[m_offer]) begin
            m_offer = -1;
            m_skip = 0;
         end else if (m_age == TIMEOUT - 1) begin
            m_offer = -1;
            m_skip = 1;
         end else begin
            m_age++;
         end
      end else if (m_service >= 0) begin
         if (wr_claim && int'(wdata[3:0]) == m_service + 1) m_service = -1;
      end else if (m_skip > 0) begin
         m_skip--;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m_pend[i] && m_en[i] && m_offer < 0) m_offer = i;
         end
         m_age = 0;
      end
      m_pend = (m_pend & ~clr) | edges;
      if (wr_en) m_en = wdata[3:0];
      m_srcq = irq_src;
      m_vec = (m_offer >= 0) ? 4'(m_offer + 1) : 4'd0;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic [3:0] s, input logic a, input logic w,
                        input logic rden, input logic [7:0] off, input logic [63:0] d);
      reset = r; irq_src = s; ack = a; we = w; re = rden;
      addr = BASE + 64'(off); wdata = d;
   endtask

   typedef struct {
      logic        r;
      logic [3:0]  s;
      logic        a;
      logic        w;
      logic        rden;
      logic [7:0]  off;
      logic [63:0] d;
      logic [3:0]  ev;
      logic [63:0] er;
   } vec_t;

   function automatic vec_t mk(logic r, logic [3:0] s, logic a, logic w, logic rden,
                               logic [7:0] off, logic [63:0] d, logic [3:0] ev, logic [63:0] er);
      vec_t v;
      v.r = r; v.s = s; v.a = a; v.w = w; v.rden = rden;
      v.off = off; v.d = d; v.ev = ev; v.er = er;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      //                 r  src   a  w  re  off    data                    vec   rd
      tbl.push_back(mk(1, 4'h0, 0, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 64'h1,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 1, 8'h08, 64'h0,                   4'd1, 64'h1));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h08, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h10, 64'h0,                   4'd0, 64'h1));
      tbl.push_back(mk(0, 4'h4, 0, 1, 0, 8'h00, 64'h5,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h4, 0, 0, 1, 8'h08, 64'h0,                   4'd0, 64'h4));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h10, 64'h1,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 8'h00, 64'h0,                   4'd3, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h08, 64'h0,                   4'd0, 64'h4));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 64'hF,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 8'h00, 64'h0,                   4'd3, 64'h0));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h10, 64'h3,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'hA, 0, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'hA, 0, 0, 0, 8'h00, 64'h0,                   4'd2, 64'h0));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h10, 64'h2,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 0, 8'h00, 64'h0,                   4'd4, 64'h0));
      tbl.push_back(mk(0, 4'h0, 1, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h10, 64'h5,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h10, 64'h0,                   4'd0, 64'h4));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h10, 64'h4,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h1, 0, 0, 0, 8'h00, 64'h0,                   4'd1, 64'h0));
      tbl.push_back(mk(1, 4'h1, 0, 0, 0, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h08, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h00, 64'hFFFF_FFFF_FFFF_FFF3, 4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h00, 64'h0,                   4'd0, 64'h3));
      tbl.push_back(mk(0, 4'h0, 0, 1, 0, 8'h08, 64'hF,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 0, 0, 1, 8'h08, 64'h0,                   4'd0, 64'h0));
      tbl.push_back(mk(0, 4'h0, 1, 0, 1, 8'h18, 64'h0,                   4'd0, 64'h0));

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].rden, tbl[i].off, tbl[i].d);
         cycle();
         $display("row %0d: rst=%0b src=%h ack=%0b we=%0b re=%0b off=%h -> vec=%0d rd=%0h",
                  i, tbl[i].r, tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].rden, tbl[i].off, vec, rd);
         chk($sformatf("row%0d_vec", i), 64'(vec), 64'(tbl[i].ev));
         chk($sformatf("row%0d_rd", i), rd, tbl[i].er);
      end

      // Ack timeout: ENABLE=3, nothing pending, source 1 edges once.
      drive(0, 4'h2, 0, 0, 0, 8'h00, 64'h0);
      cycle();
      chk("to_edge_vec", 64'(vec), 64'd0);
      cycle();
      chk("to_assert_vec", 64'(vec), 64'd2);
      for (int k = 1; k < TIMEOUT; k++) begin
         cycle();
         chk($sformatf("to_hold%0d_vec", k), 64'(vec), 64'd2);
      end
      cycle();
      chk("to_gap_vec", 64'(vec), 64'd0);
      drive(0, 4'h2, 0, 0, 1, 8'h08, 64'h0);
      cycle();
      chk("to_idle_vec", 64'(vec), 64'd0);
      chk("to_pending", rd, 64'h2);
      drive(0, 4'h2, 0, 0, 0, 8'h00, 64'h0);
      cycle();
      chk("to_reassert_vec", 64'(vec), 64'd2);
      $display("timeout sequence: vector withdrawn after %0d cycles and re-presented", TIMEOUT);

      // Ack together with an enable write that clears the bit: ack wins.
      drive(0, 4'h2, 1, 1, 0, 8'h00, 64'h0);
      cycle();
      chk("ackwin_vec", 64'(vec), 64'd0);
      drive(0, 4'h2, 0, 0, 1, 8'h10, 64'h0);
      cycle();
      chk("ackwin_claim", rd, 64'h2);
      $display("ack/withdraw race: claim reads %0h", rd);

      // Randomized traffic against the model.
      drive(1, 4'h0, 0, 0, 0, 8'h00, 64'h0);
      cycle();
      chk("rnd_reset_vec", 64'(vec), 64'(m_vec));
      for (int n = 0; n < 4000; n++) begin
         int sel;
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
         ack = ($urandom_range(0, 9) == 0);
         we = 1'b0; re = 1'b0; wdata = '0; addr = BASE;
         sel = $urandom_range(0, 7);
         case (sel)
            0: begin we = 1'b1; addr = BASE;           wdata = {$urandom, $urandom}; end
            1: begin we = 1'b1; addr = BASE + 64'h10;  wdata = 64'($urandom_range(0, 5)); end
            2: begin we = 1'b1; addr = BASE + 64'h8;   wdata = 64'($urandom); end
            3, 4: begin re = 1'b1; addr = BASE + 64'(8 * $urandom_range(0, 3)); end
            default: ;
         endcase
         cycle();
         if (we || re)
            $display("rnd %0d: %s addr=%0h data=%0h -> vec=%0d rd=%0h",
                     n, we ? "wr" : "rd", addr, wdata, vec, rd);
         chk($sformatf("rnd%0d_vec", n), 64'(vec), 64'(m_vec));
         chk($sformatf("rnd%0d_rd", n), rd, m_rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
